// File: rtl/signal_head_driver_pkg.sv
// Shared encodings for the traffic_light -> signal_head_driver interface:
// colors, one-hot actions, fault codes, driver states and the color/action pairing rules.
package traffic_pkg;

  typedef enum logic [1:0] {
    COLOR_RED     = 2'b00,
    COLOR_GREEN   = 2'b01,
    COLOR_YELLOW  = 2'b10,
    COLOR_ILLEGAL = 2'b11
  } color_e;

  localparam logic [2:0] ACT_STOP    = 3'b001;
  localparam logic [2:0] ACT_CAUTION = 3'b010;
  localparam logic [2:0] ACT_GO      = 3'b100;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_ILLEGAL  = 2'b01,
    FC_SEQUENCE = 2'b10,
    FC_MISMATCH = 2'b11
  } fault_code_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  function automatic logic [2:0] expected_action(input color_e c);
    case (c)
      COLOR_RED:    return ACT_STOP;
      COLOR_GREEN:  return ACT_GO;
      COLOR_YELLOW: return ACT_CAUTION;
      default:      return 3'b000;
    endcase
  endfunction

  // The only color allowed to follow a given color.
  function automatic color_e legal_next(input color_e c);
    case (c)
      COLOR_RED:    return COLOR_GREEN;
      COLOR_GREEN:  return COLOR_YELLOW;
      COLOR_YELLOW: return COLOR_RED;
      default:      return COLOR_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/signal_head_driver_flash_gen.sv
// Square-wave phase generator for the fault flash; holds the on-phase while disabled
// so every enable rising edge starts with a full on half-period.
module flash_gen #(
  parameter int FLASH_HALF = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic phase
);

  localparam logic [7:0] LAST_C = 8'(FLASH_HALF - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       ph_q, ph_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ph_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    if (!enable) begin
      cnt_d = '0;
      ph_d  = 1'b1;
    end else if (cnt_q == LAST_C) begin
      cnt_d = '0;
      ph_d  = ~ph_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign phase = ph_q;

endmodule

// File: rtl/signal_head_driver.sv
// Lamp driver for one signal head: registers color/action, checks sequencing and encoding,
// and falls back to sticky flashing red on fault. Optional LAMP_CHANGE_CNT_EN adds change_cnt.
module signal_head_driver
  import traffic_pkg::*;
#(
  parameter int MIN_ON       = 4,
  parameter int FLASH_HALF   = 8,
  parameter int MISMATCH_LIM = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  color,
  input  logic [2:0]  action,
  output logic        lamp_red,
  output logic        lamp_yellow,
  output logic        lamp_green,
  output logic        fault,
  output logic [1:0]  fault_code
`ifdef LAMP_CHANGE_CNT_EN
  ,
  output logic [15:0] change_cnt
`endif
);

  localparam logic [7:0] MIN_ON_C  = 8'(MIN_ON);
  localparam logic [3:0] MIS_LIM_C = 4'(MISMATCH_LIM);

  color_e      c_q;
  logic [2:0]  a_q;
  state_e      state_q, state_d;
  color_e      disp_q, disp_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  mis_q, mis_d;
  fault_code_e code_q, code_d;

  logic       illegal, changed, seqBad, misBad, changeOk;
  logic [3:0] misNext;
  logic       flashOn;

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q     <= COLOR_RED;
      a_q     <= ACT_STOP;
      state_q <= ST_INIT;
      disp_q  <= COLOR_RED;
      hold_q  <= '0;
      mis_q   <= '0;
      code_q  <= FC_NONE;
    end else begin
      c_q     <= color_e'(color);
      a_q     <= action;
      state_q <= state_d;
      disp_q  <= disp_d;
      hold_q  <= hold_d;
      mis_q   <= mis_d;
      code_q  <= code_d;
    end
  end

  // Fault checks all look at the stage-1 sample against the color currently on display.
  always_comb begin
    illegal  = (c_q == COLOR_ILLEGAL);
    changed  = (c_q != disp_q);
    seqBad   = changed && ((c_q != legal_next(disp_q)) || (hold_q < MIN_ON_C));
    if (a_q != expected_action(c_q))
      misNext = (mis_q == 4'hF) ? mis_q : mis_q + 4'd1;
    else
      misNext = '0;
    misBad   = (misNext >= MIS_LIM_C);

    state_d  = state_q;
    disp_d   = disp_q;
    hold_d   = hold_q;
    mis_d    = mis_q;
    code_d   = code_q;
    changeOk = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (c_q == COLOR_RED) begin
          state_d = ST_RUN;
          disp_d  = COLOR_RED;
          hold_d  = 8'd1;
          mis_d   = '0;
        end
      end
      ST_RUN: begin
        if (illegal) begin
          state_d = ST_FAULT;
          code_d  = FC_ILLEGAL;
        end else if (seqBad) begin
          state_d = ST_FAULT;
          code_d  = FC_SEQUENCE;
        end else if (misBad) begin
          state_d = ST_FAULT;
          code_d  = FC_MISMATCH;
        end else begin
          mis_d = misNext;
          if (changed) begin
            disp_d   = c_q;
            hold_d   = 8'd1;
            changeOk = 1'b1;
          end else if (hold_q < MIN_ON_C) begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      ST_FAULT: ;
      default: state_d = ST_FAULT;
    endcase
  end

  flash_gen #(.FLASH_HALF(FLASH_HALF)) u_flash (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q == ST_FAULT),
    .phase  (flashOn)
  );

  // At most one lamp is ever driven; anything outside RUN shows red (steady or flashing).
  always_comb begin
    lamp_red    = 1'b0;
    lamp_yellow = 1'b0;
    lamp_green  = 1'b0;
    case (state_q)
      ST_INIT: lamp_red = 1'b1;
      ST_RUN: begin
        case (disp_q)
          COLOR_GREEN:  lamp_green  = 1'b1;
          COLOR_YELLOW: lamp_yellow = 1'b1;
          default:      lamp_red    = 1'b1;
        endcase
      end
      default: lamp_red = flashOn;
    endcase
  end

  assign fault      = (state_q == ST_FAULT);
  assign fault_code = code_q;

`ifdef LAMP_CHANGE_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (changeOk && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign change_cnt = cnt_q;
`else
  logic unusedChangeOk;
  assign unusedChangeOk = changeOk;
`endif

endmodule

// File: tb/tb_signal_head_driver.sv
// Scoreboard bench for signal_head_driver: directed vectors push hand-computed lamp/fault
// expectations tagged with the clock edge they become visible; a negedge monitor compares.
module tb_signal_head_driver;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  localparam logic [1:0] C_RED = 2'b00, C_GRN = 2'b01, C_YEL = 2'b10, C_BAD = 2'b11;
  localparam logic [2:0] A_STOP = 3'b001, A_CAU = 3'b010, A_GO = 3'b100;

  logic        clk;
  logic        reset;
  logic [1:0]  color;
  logic [2:0]  action;
  logic        lampRed, lampYellow, lampGreen, faultOut;
  logic [1:0]  faultCode;
  logic [15:0] changeCnt;

  typedef struct {
    int          due;
    logic [2:0]  lamps;
    logic        flt;
    logic [1:0]  code;
    logic [15:0] cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   edgeCnt = 0;
  int   assertCnt = 0;
  int   failCnt = 0;

  signal_head_driver dut (
    .clk         (clk),
    .reset       (reset),
    .color       (color),
    .action      (action),
    .lamp_red    (lampRed),
    .lamp_yellow (lampYellow),
    .lamp_green  (lampGreen),
    .fault       (faultOut),
    .fault_code  (faultCode)
`ifdef LAMP_CHANGE_CNT_EN
    ,
    .change_cnt  (changeCnt)
`endif
  );

`ifndef LAMP_CHANGE_CNT_EN
  assign changeCnt = 16'h0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Monitor: compares every expectation that has become due at this edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= edgeCnt) begin
      cur = sb.pop_front();
      assertCnt++;
      if (cur.due < edgeCnt) begin
        failCnt++;
        $display("[TB] FAIL %s: check missed (due edge %0d, now %0d)", cur.name, cur.due, edgeCnt);
      end else if (!({lampRed, lampYellow, lampGreen} === cur.lamps && faultOut === cur.flt &&
                     faultCode === cur.code
`ifdef LAMP_CHANGE_CNT_EN
                     && changeCnt === cur.cnt
`endif
                    )) begin
        failCnt++;
        $display("[TB] FAIL %s @edge %0d: got lamps=%b fault=%b code=%b cnt=%0d, expected lamps=%b fault=%b code=%b cnt=%0d",
                 cur.name, edgeCnt, {lampRed, lampYellow, lampGreen}, faultOut, faultCode, changeCnt,
                 cur.lamps, cur.flt, cur.code, cur.cnt);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] c, input logic [2:0] a);
    color  = c;
    action = a;
  endtask

  // Queue an expectation visible d edges from now, kept sorted by due edge.
  task automatic checkOutput(input int d, input logic [2:0] l, input logic f,
                             input logic [1:0] code, input logic [15:0] n, input string nm);
    exp_t e;
    int   pos;
    e.due = edgeCnt + d; e.lamps = l; e.flt = f; e.code = code; e.cnt = n; e.name = nm;
    pos = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > e.due) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset(input string nm);
    reset = 1'b1;
    applyStimulus(C_RED, A_STOP);
    checkOutput(1, L_RED, 1'b0, 2'b00, 16'd0, nm);
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    color  = C_RED;
    action = A_STOP;

    // 1: reset then steady red
    doReset("t1_reset");
    checkOutput(2, L_RED, 1'b0, 2'b00, 16'd0, "t1_run_red");
    idle(6);

    // 2: full legal cycle, lamps lag the pins by two edges
    applyStimulus(C_GRN, A_GO);
    checkOutput(1, L_RED, 1'b0, 2'b00, 16'd0, "t2_red_lag");
    checkOutput(2, L_GRN, 1'b0, 2'b00, 16'd1, "t2_green");
    idle(6);
    applyStimulus(C_YEL, A_CAU);
    checkOutput(1, L_GRN, 1'b0, 2'b00, 16'd1, "t2_green_lag");
    checkOutput(2, L_YEL, 1'b0, 2'b00, 16'd2, "t2_yellow");
    idle(6);
    applyStimulus(C_RED, A_STOP);
    checkOutput(1, L_YEL, 1'b0, 2'b00, 16'd2, "t2_yellow_lag");
    checkOutput(2, L_RED, 1'b0, 2'b00, 16'd3, "t2_red_again");
    idle(6);

    // 3: green held only two cycles -> early change fault and flash timing
    doReset("t3_reset");
    idle(6);
    applyStimulus(C_GRN, A_GO);
    checkOutput(2, L_GRN, 1'b0, 2'b00, 16'd1, "t3_green");
    idle(2);
    applyStimulus(C_YEL, A_CAU);
    checkOutput(1, L_GRN, 1'b0, 2'b00, 16'd1, "t3_green_lag");
    checkOutput(2, L_RED, 1'b1, 2'b10, 16'd1, "t3_fault_on");
    checkOutput(9, L_RED, 1'b1, 2'b10, 16'd1, "t3_on_last");
    checkOutput(10, L_OFF, 1'b1, 2'b10, 16'd1, "t3_off_first");
    checkOutput(17, L_OFF, 1'b1, 2'b10, 16'd1, "t3_off_last");
    checkOutput(18, L_RED, 1'b1, 2'b10, 16'd1, "t3_on_again");
    idle(20);

    // 4: illegal color coinciding with mismatch limit -> code 01, sticky
    doReset("t4_reset");
    idle(6);
    applyStimulus(C_RED, A_GO);
    checkOutput(2, L_RED, 1'b0, 2'b00, 16'd0, "t4_one_mismatch");
    idle(1);
    applyStimulus(C_BAD, A_GO);
    checkOutput(2, L_RED, 1'b1, 2'b01, 16'd0, "t4_illegal_prio");
    idle(2);
    applyStimulus(C_RED, A_STOP);
    checkOutput(5, L_RED, 1'b1, 2'b01, 16'd0, "t4_sticky_on");
    checkOutput(9, L_OFF, 1'b1, 2'b01, 16'd0, "t4_sticky_off");
    idle(12);

    // 5a: one-cycle mismatch is tolerated
    doReset("t5a_reset");
    idle(6);
    applyStimulus(C_GRN, A_STOP);
    checkOutput(2, L_GRN, 1'b0, 2'b00, 16'd1, "t5a_green");
    idle(1);
    applyStimulus(C_GRN, A_GO);
    checkOutput(4, L_GRN, 1'b0, 2'b00, 16'd1, "t5a_no_fault");
    idle(6);

    // 5b: two-cycle mismatch -> code 11
    doReset("t5b_reset");
    idle(6);
    applyStimulus(C_GRN, A_STOP);
    checkOutput(2, L_GRN, 1'b0, 2'b00, 16'd1, "t5b_green");
    checkOutput(3, L_RED, 1'b1, 2'b11, 16'd1, "t5b_mismatch");
    idle(2);
    applyStimulus(C_GRN, A_GO);
    idle(9);

    // 6: reset during flash-off phase clears everything
    checkOutput(0, L_OFF, 1'b1, 2'b11, 16'd1, "t6_in_off_phase");
    reset = 1'b1;
    applyStimulus(C_RED, A_STOP);
    checkOutput(1, L_RED, 1'b0, 2'b00, 16'd0, "t6_reset_clears");
    idle(2);
    reset = 1'b0;
    checkOutput(3, L_RED, 1'b0, 2'b00, 16'd0, "t6_after_release");
    idle(4);

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      assertCnt++;
      failCnt++;
      $display("[TB] FAIL drain_timeout: %0d expectations pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
